// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined Hamming SEC / SEC-DED decoder with saturating error counters.
// Latency 2 cycles; in_ready falls only when both stages hold a word and out_ready is low.
module hamming_secded_decoder_pipe #(
   parameter int DATA_W   = 7,
   parameter int PAR_W    = 4,
   parameter int EXTENDED = 1,
   parameter int CNT_W    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_W+PAR_W+EXTENDED-1:0] in_code,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_W-1:0]                out_data,
   output logic [PAR_W-1:0]                 out_syndrome,
   output logic [1:0]                       out_status,
   input  logic                             cnt_clr,
   output logic [CNT_W-1:0]                 cnt_corr,
   output logic [CNT_W-1:0]                 cnt_uncorr
);

   localparam int HAM_W  = DATA_W + PAR_W;
   localparam int CODE_W = HAM_W + EXTENDED;

   localparam logic [1:0] ST_OK     = 2'b00;
   localparam logic [1:0] ST_CORR   = 2'b01;
   localparam logic [1:0] ST_UNCORR = 2'b10;

   if ((2 ** PAR_W) < (HAM_W + 1)) begin : g_bad_params
      $error("PAR_W too small for DATA_W");
   end

   // Positions (1-based) whose bit k is set: the span of parity bit P_k.
   function automatic logic [HAM_W-1:0] cover_mask(input int k);
      logic [HAM_W-1:0] m;
      m = '0;
      for (int p = 1; p <= HAM_W; p++) begin
         if (((p >> k) & 1) != 0) m = m | (HAM_W'(1) << (p - 1));
      end
      return m;
   endfunction

   function automatic logic [HAM_W-1:0] parity_mask();
      logic [HAM_W-1:0] m;
      m = '0;
      for (int p = 1; p <= HAM_W; p++) begin
         if ((p & (p - 1)) == 0) m = m | (HAM_W'(1) << (p - 1));
      end
      return m;
   endfunction

   // Hamming position holding data bit j (non-power-of-two slots, ascending).
   function automatic int data_pos(input int j);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 1; p <= HAM_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == j) pos = p;
            cnt = cnt + 1;
         end
      end
      return pos;
   endfunction

   localparam logic [HAM_W-1:0] PAR_MASK = parity_mask();
   localparam logic [PAR_W-1:0] HAM_P    = PAR_W'(HAM_W);

   logic              s1_en;
   logic              s2_en;
   logic              s1_valid;
   logic [HAM_W-1:0]  s1_code;
   logic [PAR_W-1:0]  s1_syn;
   logic              s1_ovr;
   logic [PAR_W-1:0]  syn_c;
   logic              ovr_c;
   logic [DATA_W-1:0] fix_data;
   logic              do_flip;
   logic [1:0]        st_c;
   logic              xfer;
   logic              unused_par;

   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en && !rst;
   assign xfer     = out_valid && out_ready;

   for (genvar k = 0; k < PAR_W; k++) begin : g_syn
      localparam logic [HAM_W-1:0] MASK = cover_mask(k);
      assign syn_c[k] = ^(in_code[HAM_W-1:0] & MASK);
   end

   if (EXTENDED != 0) begin : g_ovr
      assign ovr_c = ^in_code;
   end else begin : g_no_ovr
      assign ovr_c = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
         s1_ovr   <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_code <= in_code[HAM_W-1:0];
            s1_syn  <= syn_c;
            s1_ovr  <= ovr_c;
         end
      end
   end

   always_comb begin
      st_c    = ST_OK;
      do_flip = 1'b0;
      if (EXTENDED != 0) begin
         if (s1_syn == '0) begin
            st_c = s1_ovr ? ST_CORR : ST_OK;
         end else if (s1_ovr && (s1_syn <= HAM_P)) begin
            st_c    = ST_CORR;
            do_flip = 1'b1;
         end else begin
            st_c = ST_UNCORR;
         end
      end else begin
         if (s1_syn == '0) begin
            st_c = ST_OK;
         end else if (s1_syn <= HAM_P) begin
            st_c    = ST_CORR;
            do_flip = 1'b1;
         end else begin
            st_c = ST_UNCORR;
         end
      end
   end

   // A parity-position error needs no data flip, so only data slots are corrected.
   for (genvar j = 0; j < DATA_W; j++) begin : g_dat
      localparam int POS = data_pos(j);
      localparam logic [PAR_W-1:0] PV = PAR_W'(POS);
      assign fix_data[j] = s1_code[POS-1] ^ (do_flip && (s1_syn == PV));
   end

   assign unused_par = ^(s1_code & PAR_MASK);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_syndrome <= '0;
         out_status   <= ST_OK;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data     <= fix_data;
            out_syndrome <= s1_syn;
            out_status   <= st_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (xfer) begin
         if ((out_status == ST_CORR) && (cnt_corr != '1))
            cnt_corr <= cnt_corr + CNT_W'(1);
         if ((out_status == ST_UNCORR) && (cnt_uncorr != '1))
            cnt_uncorr <= cnt_uncorr + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Scoreboard bench for hamming_secded_decoder_pipe (DATA_W=7, PAR_W=4, EXTENDED=1).
// A second instance with 2-bit counters covers saturation.
module tb_hamming_secded_decoder_pipe;

   typedef struct packed {
      logic [6:0] data;
      logic [3:0] syn;
      logic [1:0] st;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_code;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_data;
   logic [3:0]  out_syndrome;
   logic [1:0]  out_status;
   logic        cnt_clr;
   logic [15:0] cnt_corr;
   logic [15:0] cnt_uncorr;
   logic [1:0]  s_cnt_corr;
   logic [1:0]  s_cnt_uncorr;
   logic        unused_s_in_ready;
   logic        unused_s_out_valid;
   logic [6:0]  unused_s_out_data;
   logic [3:0]  unused_s_out_syndrome;
   logic [1:0]  unused_s_out_status;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   int   mode  = 0;
   int   m_corr, m_unc, ms_corr, ms_unc;

   always #5 clk = ~clk;

   hamming_secded_decoder_pipe #(.DATA_W(7), .PAR_W(4), .EXTENDED(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_syndrome(out_syndrome), .out_status(out_status), .cnt_clr(cnt_clr),
      .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr));

   hamming_secded_decoder_pipe #(.DATA_W(7), .PAR_W(4), .EXTENDED(1), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_s_in_ready), .in_code(in_code),
      .out_valid(unused_s_out_valid), .out_ready(out_ready), .out_data(unused_s_out_data),
      .out_syndrome(unused_s_out_syndrome), .out_status(unused_s_out_status), .cnt_clr(cnt_clr),
      .cnt_corr(s_cnt_corr), .cnt_uncorr(s_cnt_uncorr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Syndrome = XOR of the positions of all set bits; overall = popcount parity.
   function automatic exp_t ref_decode(input logic [11:0] c);
      exp_t r;
      int s;
      int j;
      logic [10:0] f;
      bit odd;
      s = 0;
      for (int p = 1; p <= 11; p++) if (c[p-1]) s = s ^ p;
      odd = ($countones(c) % 2) == 1;
      f = c[10:0];
      r = '0;
      if (s == 0) r.st = odd ? 2'b01 : 2'b00;
      else if (odd && s <= 11) begin
         r.st = 2'b01;
         f[s-1] = ~f[s-1];
      end else r.st = 2'b10;
      j = 0;
      for (int p = 1; p <= 11; p++) begin
         if ((p & (p - 1)) != 0) begin
            r.data[j] = f[p-1];
            j++;
         end
      end
      r.syn = 4'(s);
      return r;
   endfunction

   function automatic logic [11:0] encode(input logic [6:0] d);
      logic [11:0] c;
      int s;
      int j;
      c = '0;
      j = 0;
      for (int p = 1; p <= 11; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p-1] = d[j];
            j++;
         end
      end
      s = 0;
      for (int p = 1; p <= 11; p++) if (c[p-1]) s = s ^ p;
      for (int k = 0; k < 4; k++) if (((s >> k) & 1) != 0) c[(1 << k) - 1] = 1'b1;
      c[11] = ^c[10:0];
      return c;
   endfunction

   function automatic logic [11:0] rand_word();
      logic [11:0] c;
      int a;
      int b;
      c = encode(7'($urandom));
      a = $urandom_range(0, 11);
      b = (a + $urandom_range(1, 11)) % 12;
      case ($urandom_range(0, 3))
         0: ;
         1: c[a] = ~c[a];
         2: begin c[a] = ~c[a]; c[b] = ~c[b]; end
         default: c = 12'($urandom);
      endcase
      return c;
   endfunction

   task automatic send(input logic [11:0] c, input bit use_exp, input exp_t e, output int waited);
      bit acc;
      acc = 1'b0;
      waited = 0;
      in_valid = 1'b1;
      in_code = c;
      while (!acc && waited < 200) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            q.push_back(use_exp ? e : ref_decode(c));
         end
         @(posedge clk);
         #1;
         waited++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no in_ready, required acceptance within 200 cycles");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pat;
      pat = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 9) < 6);
            2: out_ready = (pat == 0) || (pat == 3);
            default: out_ready = 1'b0;
         endcase
         pat = (pat + 1) % 4;
      end
   end

   // Monitor: counters, in_ready, hold-while-stalled and in-order output checks.
   initial begin
      bit   prev_stall;
      exp_t held;
      exp_t e;
      int   occ;
      prev_stall = 1'b0;
      held = '0;
      m_corr = 0; m_unc = 0; ms_corr = 0; ms_unc = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            q.delete();
            m_corr = 0; m_unc = 0; ms_corr = 0; ms_unc = 0;
            prev_stall = 1'b0;
         end else begin
            chk("cnt_corr", 32'(cnt_corr), 32'(m_corr));
            chk("cnt_uncorr", 32'(cnt_uncorr), 32'(m_unc));
            chk("sat_cnt_corr", 32'(s_cnt_corr), 32'(ms_corr));
            chk("sat_cnt_uncorr", 32'(s_cnt_uncorr), 32'(ms_unc));
            occ = q.size() - ((in_valid && in_ready) ? 1 : 0);
            chk("in_ready", 32'(in_ready), 32'(!(occ >= 2 && !out_ready)));
            if (prev_stall) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_fields", 32'({out_data, out_syndrome, out_status}), 32'(held));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_output: got data %0h with nothing outstanding", out_data);
               end else begin
                  e = q.pop_front();
                  chk("out_data", 32'(out_data), 32'(e.data));
                  chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
                  chk("out_status", 32'(out_status), 32'(e.st));
                  if (!cnt_clr) begin
                     if (e.st == 2'b01) begin
                        if (m_corr < 65535) m_corr++;
                        if (ms_corr < 3) ms_corr++;
                     end
                     if (e.st == 2'b10) begin
                        if (m_unc < 65535) m_unc++;
                        if (ms_unc < 3) ms_unc++;
                     end
                  end
               end
            end
            if (cnt_clr) begin
               m_corr = 0; m_unc = 0; ms_corr = 0; ms_unc = 0;
            end
            prev_stall = out_valid && !out_ready;
            held = '{data: out_data, syn: out_syndrome, st: out_status};
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required completion within time limit");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int   w;
      exp_t e;
      logic [11:0] c;
      rst = 1'b1; in_valid = 1'b0; in_code = '0; cnt_clr = 1'b0; mode = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_syndrome", 32'(out_syndrome), 32'd0);
      chk("rst_status", 32'(out_status), 32'd0);
      chk("rst_cnt_corr", 32'(cnt_corr), 32'd0);
      chk("rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      e = '{data: 7'h55, syn: 4'h0, st: 2'b00}; send(12'hD2F, 1'b1, e, w);
      e = '{data: 7'h55, syn: 4'h5, st: 2'b01}; send(12'hD3F, 1'b1, e, w);
      e = '{data: 7'h55, syn: 4'h0, st: 2'b01}; send(12'h52F, 1'b1, e, w);
      e = '{data: 7'h57, syn: 4'h4, st: 2'b10}; send(12'hD3E, 1'b1, e, w);
      e = '{data: 7'h45, syn: 4'hC, st: 2'b10}; send(12'hC26, 1'b1, e, w);
      drain();

      mode = 2;
      for (int i = 0; i < 8; i++) send(rand_word(), 1'b0, e, w);
      drain();

      mode = 1;
      for (int i = 0; i < 300; i++) begin
         cnt_clr = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 7) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send(rand_word(), 1'b0, e, w);
      end
      cnt_clr = 1'b0;
      drain();

      mode = 0;
      drain();
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         c = encode(7'($urandom));
         c[i] = ~c[i];
         send(c, 1'b0, e, w);
      end
      drain();
      chk("sat_five_corrected", 32'(s_cnt_corr), 32'd3);
      cnt_clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         c = encode(7'($urandom));
         c[i + 4] = ~c[i + 4];
         send(c, 1'b0, e, w);
      end
      drain();
      cnt_clr = 1'b0;
      chk("clr_wins_main", 32'(cnt_corr), 32'd0);
      chk("clr_wins_sat", 32'(s_cnt_corr), 32'd0);

      mode = 3;
      repeat (2) @(posedge clk);
      #1;
      send(rand_word(), 1'b0, e, w);
      send(rand_word(), 1'b0, e, w);
      rst = 1'b1;
      mode = 0;
      @(posedge clk);
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_outputs", 32'({out_data, out_syndrome, out_status}), 32'd0);
      chk("mid_rst_counters", 32'({cnt_corr, cnt_uncorr}), 32'd0);
      rst = 1'b0;
      c = encode(7'h2A);
      c[6] = ~c[6];
      send(c, 1'b0, e, w);
      chk("first_accept_cycles", 32'(w), 32'd1);
      @(negedge clk);
      chk("latency_not_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_two", 32'(out_valid), 32'd1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
